bank_write_arbiter: RTL
=======================

BANK_WRITE_ARBITER -- requirements
Module: bank_write_arbiter

Interface
REQ-001 Parameter W, default 16, data word width; SHALL equal the attached bank FIFO word width.
REQ-002 Parameter N, default 8, FIFO depth exponent (2^N words, 2^(N-1) words per bank); SHALL equal the FIFO N.
REQ-003 Parameter PAD_WORD, default 0 (W bits), fill word written to complete a partial bank.
REQ-004 clk  in  1  single clock; shared with the FIFO write-side clock.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 a_req  in  1  requester A wants FIFO ownership; sampled only in IDLE.
REQ-007 a_valid  in  1  a_data valid.
REQ-008 a_data  in  W  requester A word.
REQ-009 a_last  in  1  marks the final word of A's packet; qualified by a_valid.
REQ-010 a_ready  out  1  A word accepted this cycle when a_valid and a_ready are both high.
REQ-011 b_req, b_valid, b_data, b_last, b_ready  SHALL have the same widths and semantics as the A ports, for requester B.
REQ-012 fifo_w_trigger  out  1  write strobe to the FIFO.
REQ-013 fifo_w_data  out  W  write data to the FIFO.
REQ-014 fifo_w_ok  in  1  FIFO can accept a write this cycle.
REQ-015 fifo_w_bank  in  1  FIFO current write bank.
REQ-016 grant  out  2  one-hot owner: bit0 = A, bit1 = B; 00 = none.
REQ-017 busy  out  1  state is not IDLE.
REQ-018 bank_err  out  1  sticky bank-misalignment flag.

Function
REQ-019 FSM states SHALL be IDLE, XFER and PAD, registered.
REQ-020 IDLE SHALL behave as follows:
- If exactly one req is high, it wins.
- If both are high, the requester not served last wins; after reset, A wins first.
- The winner's grant bit is registered, and the FSM enters XFER the next cycle.
- In IDLE, a_ready = b_ready = 0 and fifo_w_trigger = 0.
REQ-021 XFER SHALL behave as follows:
- owner_ready = fifo_w_ok; non-owner ready = 0.
- fifo_w_trigger = owner_valid & fifo_w_ok.
- fifo_w_data = owner_data.
- These paths SHALL be combinational, so accept and write occur in the same cycle.
REQ-022 Position counter pos[N-2:0] and bank bit eb SHALL advance by 1 on every cycle where fifo_w_trigger = 1, including PAD writes; eb toggles when pos wraps from 2^(N-1)-1 to 0.
REQ-023 Accepted owner word with last = 1 at pos = 2^(N-1)-1 SHALL transition XFER -> IDLE with no padding.
REQ-024 Accepted owner word with last = 1 at any other pos SHALL transition XFER -> PAD.
REQ-025 Bank boundary reached without last SHALL keep the owner in XFER into the next bank; grant is never revoked mid-packet.
REQ-026 Owner req deasserting during XFER SHALL be ignored; only last ends ownership.
REQ-027 PAD SHALL behave as follows:
- fifo_w_data = PAD_WORD and fifo_w_trigger = fifo_w_ok.
- Both ready outputs = 0.
- The write at pos = 2^(N-1)-1 SHALL transition PAD -> IDLE.
REQ-028 On leaving XFER or PAD to IDLE, grant SHALL go to 00 and the last-served requester SHALL be recorded.
REQ-029 fifo_w_ok = 0 SHALL stall in every state: no trigger, no ready, pos and state unchanged.
REQ-030 bank_err SHALL set to 1 on any clock where eb != fifo_w_bank, and stay set until reset.
REQ-031 Consequence: the arbiter never interleaves requesters within a bank, and every bank is fully written before ownership changes.

Reset
REQ-032 While rst_n = 0, all of the following SHALL hold:
- state = IDLE, grant = 00, pos = 0, eb = 0.
- last-served = B, so A has first priority.
- bank_err = 0, busy = 0.
- a_ready = b_ready = fifo_w_trigger = 0, fifo_w_data = 0.
REQ-033 rst_n SHALL be asserted only together with reinitialising the FIFO write address to 0.
REQ-034 Reset mid-packet SHALL abandon the packet with no padding; any resulting misalignment SHALL be reported via bank_err.

Verification
REQ-035 N=4 (8-word banks), both req high at the first cycle after reset -> grant = 01, A sends 8 words with last on word 8 -> 8 writes, IDLE, no pad, B granted next.
REQ-036 A sends 3 words with last on word 3 -> 3 data writes then 5 writes of PAD_WORD, then IDLE; pos = 0, eb toggled.
REQ-037 A sends 12 words with last on word 12 -> grant held across the bank boundary, 4 pad writes, and B is never ready during this time.
REQ-038 fifo_w_ok held low for 10 cycles mid-XFER and mid-PAD -> no triggers, pos frozen, transfer resumes exactly in place.
REQ-039 fifo_w_bank forced to differ from eb for 1 cycle -> bank_err = 1 and stays set until rst_n is pulsed low.
REQ-040 rst_n pulsed low mid-PAD -> all outputs are 0 asynchronously, state = IDLE, and after release A has priority.

Source files
------------

// File: rtl/bank_write_arbiter.sv
// bank_write_arbiter
// Grants one of two packet sources exclusive write access to a banked FIFO.
// The owner streams words straight through to the FIFO write port. If a
// packet ends part-way through a bank, the remainder of that bank is filled
// with PAD_WORD before ownership is released. The result is that a bank
// never holds words from both sources. A local copy of the FIFO write
// position (pos/eb) is compared with the FIFO's own bank bit, and any
// disagreement is latched in bank_err.

module bank_write_arbiter #(
  parameter int            W        = 16,
  parameter int            N        = 8,
  parameter logic [W-1:0]  PAD_WORD = '0
) (
  input  logic         clk,
  input  logic         rst_n,

  input  logic         a_req,
  input  logic         a_valid,
  input  logic [W-1:0] a_data,
  input  logic         a_last,
  output logic         a_ready,

  input  logic         b_req,
  input  logic         b_valid,
  input  logic [W-1:0] b_data,
  input  logic         b_last,
  output logic         b_ready,

  output logic         fifo_w_trigger,
  output logic [W-1:0] fifo_w_data,
  input  logic         fifo_w_ok,
  input  logic         fifo_w_bank,

  output logic [1:0]   grant,
  output logic         busy,
  output logic         bank_err
);

  // Word offset inside a bank: 2^(N-1) words per bank.
  localparam int              PW      = N - 1;
  localparam logic [PW-1:0]   POS_ONE = PW'(1);
  localparam logic [PW-1:0]   POS_END = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    PAD  = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   pos;
  logic            eb;
  logic            last_b;      // 1 = B was served most recently

  logic            owner_valid;
  logic [W-1:0]    owner_data;
  logic            owner_last;
  logic            bank_end;
  logic            a_wins;

  // Multiplex the current owner's stream; grant is one-hot, so bit1 selects B.
  always_comb begin
    owner_valid = a_valid;
    owner_data  = a_data;
    owner_last  = a_last;
    if (grant[1]) begin
      owner_valid = b_valid;
      owner_data  = b_data;
      owner_last  = b_last;
    end
  end

  assign bank_end = (pos == POS_END);

  // A wins when it asks alone, or when both ask and B was served last.
  assign a_wins = a_req && (!b_req || last_b);

  assign busy = (state != IDLE);

  // Handshake and FIFO write port: combinational so accept and write coincide.
  always_comb begin
    a_ready        = 1'b0;
    b_ready        = 1'b0;
    fifo_w_trigger = 1'b0;
    fifo_w_data    = '0;
    unique case (state)
      XFER: begin
        a_ready        = grant[0] & fifo_w_ok;
        b_ready        = grant[1] & fifo_w_ok;
        fifo_w_trigger = owner_valid & fifo_w_ok;
        fifo_w_data    = owner_data;
      end
      PAD: begin
        fifo_w_trigger = fifo_w_ok;
        fifo_w_data    = PAD_WORD;
      end
      default: begin
        a_ready        = 1'b0;
        b_ready        = 1'b0;
        fifo_w_trigger = 1'b0;
        fifo_w_data    = '0;
      end
    endcase
  end

  // Track the FIFO write position; it moves on every write, data or pad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
      eb  <= 1'b0;
    end else if (fifo_w_trigger) begin
      pos <= pos + POS_ONE;
      if (bank_end) begin
        eb <= ~eb;
      end
    end
  end

  // Sticky flag: our bank bit and the FIFO's bank bit must always agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_err <= 1'b0;
    end else if (eb != fifo_w_bank) begin
      bank_err <= 1'b1;
    end
  end

  // Ownership FSM: arbitrate in IDLE, stream in XFER, fill the bank in PAD.
  // A stalled FIFO (fifo_w_ok low) freezes every state, including arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= 2'b00;
      last_b <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (fifo_w_ok) begin
            if (a_wins) begin
              grant <= 2'b01;
              state <= XFER;
            end else if (b_req) begin
              grant <= 2'b10;
              state <= XFER;
            end
          end
        end
        XFER: begin
          // Only an accepted last word ends the packet; req is ignored here.
          if (fifo_w_trigger && owner_last) begin
            if (bank_end) begin
              state  <= IDLE;
              grant  <= 2'b00;
              last_b <= grant[1];
            end else begin
              state  <= PAD;
            end
          end
        end
        PAD: begin
          if (fifo_w_trigger && bank_end) begin
            state  <= IDLE;
            grant  <= 2'b00;
            last_b <= grant[1];
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule
